// File: rtl/spiker_adapter_ctrl_pkg.sv
// Shared definitions for the spiker adapter control path: sequencer state
// encoding and the status-bit layout seen by the register file.
package spiker_adapter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4
  } spiker_seq_state_e;

  localparam int unsigned STATUS_DONE_IDX        = 0;
  localparam int unsigned STATUS_ERR_TIMEOUT_IDX = 1;
  localparam int unsigned STATUS_BUSY_IDX        = 2;
  localparam int unsigned STATUS_W               = 3;

  // Packs the sequencer flags into the register-file status word.
  function automatic logic [STATUS_W-1:0] pack_status(input logic done,
                                                      input logic err_timeout,
                                                      input logic busy);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_DONE_IDX]        = done;
    s[STATUS_ERR_TIMEOUT_IDX] = err_timeout;
    s[STATUS_BUSY_IDX]        = busy;
    return s;
  endfunction

endpackage

// File: rtl/spiker_sequencer_if.sv
// Start/done handshake between the sequencer (master) and the spiker core (slave).
interface spiker_sequencer_if;
  // core_start_o is held high until the core answers with core_ack_i in the
  // same cycle; the request is consumed on that edge. core_done_i is a
  // single-cycle result-valid that the sequencer only honours after the ack.
  logic core_start_o;
  logic core_ack_i;
  logic core_done_i;

  modport master (
    output core_start_o,
    input  core_ack_i,
    input  core_done_i
  );

  modport slave (
    input  core_start_o,
    output core_ack_i,
    output core_done_i
  );
endinterface

// File: rtl/spiker_sequencer.sv
// Runs one spiker inference per start request, waits for the core with a
// programmable timeout and issues the one-cycle result capture strobe.
module spiker_sequencer
  import spiker_adapter_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W     = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 clr_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  spiker_sequencer_if.master   core,
  output logic                 sample_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_timeout_o,
  output logic                 irq_o,
  output logic [TIMEOUT_W-1:0] cycles_o,
  output spiker_seq_state_e    state_o
);

  localparam int unsigned SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  spiker_seq_state_e    state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 wait_expired;
  logic                 finish_run;
  logic                 timed_out;
  logic                 start_ok;
  logic                 core_start_q, sample_q, busy_q;
  logic                 done_q, err_q, irq_q;
  logic [TIMEOUT_W-1:0] cycles_q;

  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign wait_expired = (timeout_i != '0) && (cnt_q == (timeout_i - 1'b1));
  assign start_ok     = (state_q == IDLE) && start_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    finish_run = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          state_d = test_mode_i ? SAMPLE : REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (wait_expired) begin
          state_d   = IDLE;
          timed_out = 1'b1;
        end else if (core.core_ack_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        // A done arriving on the last permitted wait cycle still counts.
        if (core.core_done_i) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = SAMPLE;
          end else begin
            state_d  = SETTLE;
            settle_d = SETTLE_W'(SETTLE_LOAD);
          end
        end else if (wait_expired) begin
          state_d   = IDLE;
          timed_out = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      SAMPLE: begin
        state_d    = IDLE;
        finish_run = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every other outcome, including a run finishing now.
    if (abort_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      finish_run = 1'b0;
      timed_out  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      settle_q     <= '0;
      core_start_q <= 1'b0;
      sample_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      core_start_q <= (state_d == REQ);
      sample_q     <= (state_d == SAMPLE);
      busy_q       <= (state_d != IDLE);
      irq_q        <= finish_run | timed_out;
      if (start_ok || clr_i) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      // Completion events land after any clear issued in the same cycle.
      if (finish_run) begin
        done_q   <= 1'b1;
        cycles_q <= cnt_q;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign core.core_start_o = core_start_q;
  assign sample_o          = sample_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_timeout_o     = err_q;
  assign irq_o             = irq_q;
  assign cycles_o          = cycles_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_spiker_sequencer.sv
// Directed bench for spiker_sequencer: a scenario-level outcome model predicts
// every output on every cycle and a single compare process checks the DUT.
module tb_spiker_sequencer;

  localparam int SETTLE = 2;
  localparam int DEPTH  = 1024;
  localparam int NEVER  = -1;

  typedef struct packed {
    logic        busy;
    logic        cs;
    logic        smp;
    logic        irq;
    logic        dn;
    logic        er;
    logic [15:0] cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        test_mode_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [15:0] timeout_i = '0;
  logic        sample_o, busy_o, done_o, err_timeout_o, irq_o;
  logic [15:0] cycles_o;
  spiker_adapter_ctrl_pkg::spiker_seq_state_e state_o;

  spiker_sequencer_if core_if();

  spiker_sequencer #(.TIMEOUT_W(16), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .start_i(start_i),
    .abort_i(abort_i), .clr_i(clr_i), .timeout_i(timeout_i), .core(core_if),
    .sample_o(sample_o), .busy_o(busy_o), .done_o(done_o),
    .err_timeout_o(err_timeout_o), .irq_o(irq_o), .cycles_o(cycles_o),
    .state_o(state_o)
  );

  // clock / reset / cycle index
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  obs_t exp_a [DEPTH];
  bit   exp_v [DEPTH];

  // model sticky state carried between scenarios
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [15:0] m_cyc  = '0;
  logic        m_irq_carry = 1'b0;

  task automatic pin(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // scoreboard compare: every cycle that has a prediction
  obs_t act;
  always @(negedge clk) begin
    if (rst_ni && cyc < DEPTH && exp_v[cyc]) begin
      act = {busy_o, core_if.core_start_o, sample_o, irq_o, done_o, err_timeout_o, cycles_o};
      n_checks++;
      if (act === exp_a[cyc]) n_pass++;
      else $display("FAIL cycle %0d outputs: got busy=%b cs=%b smp=%b irq=%b done=%b err=%b cyc=%0d, required busy=%b cs=%b smp=%b irq=%b done=%b err=%b cyc=%0d",
                    cyc, act.busy, act.cs, act.smp, act.irq, act.dn, act.er, act.cyc,
                    exp_a[cyc].busy, exp_a[cyc].cs, exp_a[cyc].smp, exp_a[cyc].irq,
                    exp_a[cyc].dn, exp_a[cyc].er, exp_a[cyc].cyc);
    end
  end

  // One run: start at r=0, then optional ack/done/abort/clear/extra start at
  // relative cycles. Called at the negedge before the run's first cycle.
  task automatic run_scn(input bit tm, input int tmo, input int ack_r, input int done_r,
                         input int abort_r, input int clr_r, input int xstart_r,
                         input int len, output int s);
    int  big, tc, end_r, samp_r, req_last, ncyc;
    bit  ok, tout, acked;
    obs_t o;
    big = 1 << 30;
    s = cyc + 1;
    samp_r = NEVER; ok = 0; tout = 0; ncyc = 0; req_last = 0;
    if (tm) begin
      samp_r = 1; end_r = 2; ok = 1;
    end else begin
      tc       = (tmo != 0) ? tmo : big;
      acked    = (ack_r >= 1) && (ack_r < tc);
      req_last = acked ? ack_r : tc;
      if (acked && done_r > ack_r && done_r <= tc) begin
        ok = 1; ncyc = done_r; samp_r = done_r + 1 + SETTLE; end_r = samp_r + 1;
      end else begin
        tout = (tmo != 0); end_r = tout ? tc + 1 : big;
      end
    end
    if (abort_r >= 1 && abort_r < end_r) begin
      end_r = abort_r + 1; ok = 0; tout = 0;
      if (req_last > abort_r) req_last = abort_r;
    end
    if (samp_r >= end_r) samp_r = NEVER;
    for (int r = 0; r <= len; r++) begin
      if (r == 1) begin m_done = 1'b0; m_err = 1'b0; end
      if (clr_r >= 0 && r == clr_r + 1) begin m_done = 1'b0; m_err = 1'b0; end
      if (r == end_r) begin
        if (ok) begin m_done = 1'b1; m_cyc = 16'(ncyc); end
        if (tout) m_err = 1'b1;
      end
      o.busy = (r >= 1) && (r < end_r);
      o.cs   = (r >= 1) && (r <= req_last);
      o.smp  = (r == samp_r);
      o.irq  = (r == 0) ? m_irq_carry : ((r == end_r) && (ok || tout));
      o.dn   = m_done;
      o.er   = m_err;
      o.cyc  = m_cyc;
      if (r < len) begin
        exp_a[s + r] = o;
        exp_v[s + r] = 1'b1;
      end else begin
        m_irq_carry = o.irq;
      end
    end
    for (int r = 0; r < len; r++) begin
      @(negedge clk);
      start_i             = (r == 0) || (r == xstart_r);
      test_mode_i         = tm;
      timeout_i           = 16'(tmo);
      core_if.core_ack_i  = (r == ack_r);
      core_if.core_done_i = (r == done_r);
      abort_i             = (r == abort_r);
      clr_i               = (r == clr_r);
    end
  endtask

  task automatic idle_inputs();
    start_i = 0; test_mode_i = 0; abort_i = 0; clr_i = 0;
    core_if.core_ack_i = 0; core_if.core_done_i = 0;
  endtask

  int s, n;

  initial begin
    idle_inputs();
    timeout_i = '0;
    repeat (2) @(negedge clk);
    pin("reset busy_o", int'(busy_o), 0);
    pin("reset core_start_o", int'(core_if.core_start_o), 0);
    pin("reset sample_o", int'(sample_o), 0);
    pin("reset done/err/irq", int'({done_o, err_timeout_o, irq_o}), 0);
    pin("reset cycles_o", int'(cycles_o), 0);
    pin("reset state idle", int'(state_o == spiker_adapter_ctrl_pkg::IDLE), 1);
    rst_ni = 1'b1;

    // nominal: ack 3 cycles after REQ, done 10 cycles into RUN
    run_scn(0, 100, 4, 14, NEVER, NEVER, NEVER, 22, s);
    pin("nominal model sample cycle", int'(exp_a[s + 17].smp), 1);
    pin("nominal model cycles_o", int'(exp_a[s + 18].cyc), 14);
    pin("nominal model irq", int'(exp_a[s + 18].irq), 1);

    // timeout, core never acks
    run_scn(0, 5, NEVER, NEVER, NEVER, NEVER, NEVER, 10, s);
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(exp_a[s + i].cs);
    pin("timeout model core_start length", n, 5);
    pin("timeout model err", int'(exp_a[s + 6].er), 1);

    // abort two cycles after ack
    run_scn(0, 100, 3, NEVER, 5, NEVER, NEVER, 12, s);

    // done on the 8th wait cycle with timeout 8
    run_scn(0, 8, 2, 8, NEVER, NEVER, NEVER, 16, s);
    pin("coincide model sample", int'(exp_a[s + 11].smp), 1);
    pin("coincide model err", int'(exp_a[s + 12].er), 0);

    // test mode, a second start while busy, then back-to-back start
    run_scn(1, 0, NEVER, NEVER, NEVER, NEVER, 1, 2, s);
    pin("testmode model sample", int'(exp_a[s + 1].smp), 1);

    // done coincident with ack in REQ is ignored -> timeout
    run_scn(0, 6, 3, 3, NEVER, NEVER, NEVER, 10, s);

    // timeout disabled, sticky clear while idle
    run_scn(0, 0, 1, 2, NEVER, 8, NEVER, 10, s);

    // reset while in SETTLE
    run_scn(0, 100, 2, 4, NEVER, NEVER, NEVER, 6, s);
    @(negedge clk);
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    pin("settle reset outputs", int'({busy_o, core_if.core_start_o, sample_o, irq_o, done_o, err_timeout_o}), 0);
    pin("settle reset cycles_o", int'(cycles_o), 0);
    pin("settle reset state idle", int'(state_o == spiker_adapter_ctrl_pkg::IDLE), 1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pin("post-reset quiet", int'({busy_o, core_if.core_start_o, sample_o, irq_o, done_o, err_timeout_o, cycles_o}), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
